// File: rtl/display_scanner.sv
// ---------------------------------------------------------------------------
// display_scanner
// Time-multiplexed seven-segment scanner for DIGITS displays sharing one
// segment bus. A prescaler divides each digit slot into a dark (blank) lead-in
// and a lit interval. Digit data is double buffered: loads land in a shadow
// register and are promoted to the active register only at a frame boundary,
// so a frame is never torn.
//
// Parameters:
//   DIGITS       number of multiplexed digits (2..8)
//   PRESCALE     clock cycles per digit slot (>= 2)
//   BLANK_CYCLES leading dark cycles of each slot (0 <= BLANK_CYCLES < PRESCALE)
//
// Ports:
//   clk          system clock
//   reset        synchronous active-high reset
//   digit_data   hex nibble per digit, nibble i = bits [4i+3:4i]
//   digit_en     per-digit enable, 0 blanks the digit
//   load         capture digit_data/digit_en into the shadow buffer
//   segs         active-high segments, bit0 = a ... bit6 = g (registered)
//   an           active-high one-hot digit select or all-zero (registered)
//   frame_done   one-cycle pulse with the first output cycle of each new frame
//
// Build option:
//   DISPLAY_SCANNER_LZB_EN  enables leading-zero blanking on the active buffer
// ---------------------------------------------------------------------------
module display_scanner #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned PRESCALE     = 50000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   digit_data,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic                  load,
  output logic [6:0]            segs,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int unsigned CNT_W  = $clog2(PRESCALE);
  localparam int unsigned IDX_W  = $clog2(DIGITS);
  localparam int unsigned DATA_W = 4 * DIGITS;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

  // Hex nibble to gfedcba segment pattern
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_act_data;
  logic [DIGITS-1:0] r_act_en;
  logic [DATA_W-1:0] r_shd_data;
  logic [DIGITS-1:0] r_shd_en;
  logic              r_pending;
  logic [6:0]        r_segs;
  logic [DIGITS-1:0] r_an;
  logic              r_wrap_q;
  logic              r_frame_done;

  logic              w_cnt_wrap;
  logic              w_frame_wrap;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic [DATA_W-1:0] w_act_data_nxt;
  logic [DIGITS-1:0] w_act_en_nxt;
  logic [DATA_W-1:0] w_shd_data_nxt;
  logic [DIGITS-1:0] w_shd_en_nxt;
  logic              w_pending_nxt;

  logic              w_show;
  logic [3:0]        w_nib;
  logic              w_sel_en;
  logic              w_sel_sup;
  logic [DIGITS-1:0] w_onehot;
  logic [DIGITS-1:0] w_sup;
  logic              w_lit;
  logic [6:0]        w_segs_nxt;
  logic [DIGITS-1:0] w_an_nxt;

  // Slot/frame counters and double-buffer update
  always_comb begin
    w_cnt_wrap     = (r_cnt == CNT_MAX);
    w_frame_wrap   = w_cnt_wrap && (r_idx == IDX_MAX);
    w_cnt_nxt      = w_cnt_wrap ? '0 : r_cnt + CNT_W'(1);
    w_idx_nxt      = r_idx;
    w_act_data_nxt = r_act_data;
    w_act_en_nxt   = r_act_en;
    w_shd_data_nxt = r_shd_data;
    w_shd_en_nxt   = r_shd_en;
    w_pending_nxt  = r_pending;

    if (w_cnt_wrap) begin
      w_idx_nxt = w_frame_wrap ? '0 : r_idx + IDX_W'(1);
    end

    if (load) begin
      w_shd_data_nxt = digit_data;
      w_shd_en_nxt   = digit_en;
    end

    if (w_frame_wrap) begin
      // A load on the boundary edge bypasses the shadow and wins over it
      if (load) begin
        w_act_data_nxt = digit_data;
        w_act_en_nxt   = digit_en;
      end else if (r_pending) begin
        w_act_data_nxt = r_shd_data;
        w_act_en_nxt   = r_shd_en;
      end
      w_pending_nxt = 1'b0;
    end else if (load) begin
      w_pending_nxt = 1'b1;
    end
  end

  // Dark lead-in of each slot
  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign w_show = 1'b1;
    end else begin : g_blank
      assign w_show = (r_cnt >= CNT_W'(BLANK_CYCLES));
    end
  endgenerate

`ifdef DISPLAY_SCANNER_LZB_EN
  // A digit is a leading zero when it and every enabled digit above it is 0
  always_comb begin
    logic hi_zero;
    logic nib_zero;
    hi_zero  = 1'b1;
    nib_zero = 1'b0;
    w_sup    = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      nib_zero = (r_act_data[4*i +: 4] == 4'h0);
      if (i != 0) begin
        w_sup[i] = hi_zero && nib_zero;
      end
      hi_zero = hi_zero && (!r_act_en[i] || nib_zero);
    end
  end
`else
  assign w_sup = '0;
`endif

  // Current-digit select and output decode
  always_comb begin
    w_nib     = 4'h0;
    w_sel_en  = 1'b0;
    w_sel_sup = 1'b0;
    w_onehot  = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib       = r_act_data[4*i +: 4];
        w_sel_en    = r_act_en[i];
        w_sel_sup   = w_sup[i];
        w_onehot[i] = 1'b1;
      end
    end
    w_lit      = w_show && w_sel_en && !w_sel_sup;
    w_segs_nxt = w_lit ? hex7(w_nib) : 7'h00;
    w_an_nxt   = w_lit ? w_onehot : '0;
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_act_data   <= '0;
      r_act_en     <= '0;
      r_shd_data   <= '0;
      r_shd_en     <= '0;
      r_pending    <= 1'b0;
      r_segs       <= '0;
      r_an         <= '0;
      r_wrap_q     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_act_data   <= w_act_data_nxt;
      r_act_en     <= w_act_en_nxt;
      r_shd_data   <= w_shd_data_nxt;
      r_shd_en     <= w_shd_en_nxt;
      r_pending    <= w_pending_nxt;
      r_segs       <= w_segs_nxt;
      r_an         <= w_an_nxt;
      // Delayed one extra cycle so the pulse lines up with digit 0's first output
      r_wrap_q     <= w_frame_wrap;
      r_frame_done <= r_wrap_q;
    end
  end

  assign segs       = r_segs;
  assign an         = r_an;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_display_scanner.sv
// ---------------------------------------------------------------------------
// tb_display_scanner
// Directed bench for display_scanner with DIGITS=4, PRESCALE=8, BLANK_CYCLES=2.
// Inputs change and outputs are sampled on the falling clock edge. k counts
// rising edges since reset release; the outputs seen after edge k describe
// scan position k-1 (slot = ((k-1)%32)/8, cycle in slot = (k-1)%8).
// ---------------------------------------------------------------------------
module tb_display_scanner;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned PRESCALE = 8;
  localparam int unsigned BLANK    = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] digit_data = '0;
  logic [3:0]  digit_en = '0;
  logic        load = 1'b0;
  logic [6:0]  segs;
  logic [3:0]  an;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int k = 0;

  logic [6:0] hex_tab [16];

  always #5 clk = ~clk;

  display_scanner #(
    .DIGITS      (DIGITS),
    .PRESCALE    (PRESCALE),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .digit_data (digit_data),
    .digit_en   (digit_en),
    .load       (load),
    .segs       (segs),
    .an         (an),
    .frame_done (frame_done)
  );

  task automatic tick();
    @(negedge clk);
    k++;
  endtask

  // One full 32-cycle frame starting at a frame boundary (k%32 == 0 on entry).
  // d/shown give what this frame must display; an optional single-cycle load
  // is issued after tick number load_off of the frame.
  task automatic scan_frame(input logic [15:0] d, input logic [3:0] shown,
                            input logic fd_first, input int load_off,
                            input logic [15:0] ld, input logic [3:0] le,
                            input string tag);
    int lit [4];
    int c, slot, cyc;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_fd;
    for (int s = 0; s < 4; s++) lit[s] = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      c    = k - 1;
      slot = (c % 32) / 8;
      cyc  = c % 8;
      if (cyc >= int'(BLANK) && shown[slot]) begin
        exp_an  = 4'(1 << slot);
        exp_seg = hex_tab[d[4*slot +: 4]];
      end else begin
        exp_an  = 4'b0;
        exp_seg = 7'h00;
      end
      exp_fd = (i == 0) && fd_first;
      checks += 3;
      if (an !== exp_an) begin
        errors++;
        $display("FAIL %s an k=%0d: got %b want %b", tag, k, an, exp_an);
      end
      if (segs !== exp_seg) begin
        errors++;
        $display("FAIL %s segs k=%0d: got %h want %h", tag, k, segs, exp_seg);
      end
      if (frame_done !== exp_fd) begin
        errors++;
        $display("FAIL %s frame_done k=%0d: got %b want %b", tag, k, frame_done, exp_fd);
      end
      if (an != 4'b0) lit[slot]++;
      if (i == load_off) begin
        digit_data = ld;
        digit_en   = le;
        load       = 1'b1;
      end else begin
        load = 1'b0;
      end
    end
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (lit[s] != (shown[s] ? 6 : 0)) begin
        errors++;
        $display("FAIL %s lit_count digit%0d: got %0d want %0d", tag, s, lit[s], shown[s] ? 6 : 0);
      end
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    digit_data = 16'hFFFF;
    digit_en   = 4'hF;
    load       = 1'b1;
    repeat (3) @(negedge clk);
    checks += 3;
    if (an !== 4'b0)      begin errors++; $display("FAIL reset an: got %b want 0000", an); end
    if (segs !== 7'h00)   begin errors++; $display("FAIL reset segs: got %h want 00", segs); end
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset frame_done: got %b want 0", frame_done); end
    load  = 1'b0;
    reset = 1'b0;
    k     = 0;
    tick();
    checks += 2;
    if (an !== 4'b0)    begin errors++; $display("FAIL first_cycle an: got %b want 0000", an); end
    if (segs !== 7'h00) begin errors++; $display("FAIL first_cycle segs: got %h want 00", segs); end
  endtask

  task automatic test_basic_scan();
    int lit_cnt = 0;
    int fd_cnt  = 0;
    digit_data = 16'h1234;
    digit_en   = 4'hF;
    load       = 1'b1;
    tick();
    load = 1'b0;
    // The load is only pending: the first frame stays dark and has no pulse
    while (k < 32) begin
      tick();
      if (an != 4'b0) lit_cnt++;
      if (frame_done) fd_cnt++;
    end
    checks += 2;
    if (lit_cnt != 0) begin errors++; $display("FAIL pre_boundary_dark: got %0d lit cycles want 0", lit_cnt); end
    if (fd_cnt != 0)  begin errors++; $display("FAIL first_frame_pulse: got %0d pulses want 0", fd_cnt); end
    scan_frame(16'h1234, 4'hF, 1'b1, -1, 16'h0, 4'h0, "basic1");
    scan_frame(16'h1234, 4'hF, 1'b1, -1, 16'h0, 4'h0, "basic2");
  endtask

  task automatic test_double_buffer();
    scan_frame(16'h1234, 4'hF, 1'b1, 10, 16'hABCD, 4'hF, "dbuf_old");
    scan_frame(16'hABCD, 4'hF, 1'b1, -1, 16'h0, 4'h0, "dbuf_new");
  endtask

  task automatic test_boundary_load();
    scan_frame(16'hABCD, 4'hF, 1'b1, 30, 16'h9E81, 4'hF, "bnd_before");
    scan_frame(16'h9E81, 4'hF, 1'b1, -1, 16'h0, 4'h0, "bnd_after");
    scan_frame(16'h9E81, 4'hF, 1'b1, -1, 16'h0, 4'h0, "bnd_hold");
  endtask

  task automatic test_enable_mask();
    scan_frame(16'h9E81, 4'hF, 1'b1, 30, 16'h1234, 4'b0101, "mask_load");
    scan_frame(16'h1234, 4'b0101, 1'b1, -1, 16'h0, 4'h0, "mask1");
    scan_frame(16'h1234, 4'b0101, 1'b1, -1, 16'h0, 4'h0, "mask2");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 0) begin
        checks++;
        if (frame_done !== 1'b1) begin errors++; $display("FAIL rstmid frame_done: got %b want 1", frame_done); end
      end
      if (i == 12) begin
        digit_data = 16'h9999;
        digit_en   = 4'hF;
        load       = 1'b1;
      end else begin
        load = 1'b0;
      end
    end
    // Slot 2, fourth cycle: digit 2 (nibble 2) is lit
    checks += 2;
    if (an !== 4'b0100)     begin errors++; $display("FAIL rstmid pre_an: got %b want 0100", an); end
    if (segs !== hex_tab[2]) begin errors++; $display("FAIL rstmid pre_segs: got %h want %h", segs, hex_tab[2]); end
    reset = 1'b1;
    tick();
    checks += 3;
    if (an !== 4'b0)         begin errors++; $display("FAIL rstmid an: got %b want 0000", an); end
    if (segs !== 7'h00)      begin errors++; $display("FAIL rstmid segs: got %h want 00", segs); end
    if (frame_done !== 1'b0) begin errors++; $display("FAIL rstmid frame_done: got %b want 0", frame_done); end
    tick();
    reset = 1'b0;
    k     = 0;
    // Active cleared and the pending 0x9999 discarded: two dark frames
    scan_frame(16'h0, 4'h0, 1'b0, -1, 16'h0, 4'h0, "rst_frame1");
    scan_frame(16'h0, 4'h0, 1'b1, 30, 16'h0070, 4'hF, "rst_frame2");
  endtask

  task automatic test_lzb();
`ifdef DISPLAY_SCANNER_LZB_EN
    scan_frame(16'h0070, 4'b0011, 1'b1, -1, 16'h0, 4'h0, "lzb_on");
`else
    scan_frame(16'h0070, 4'hF, 1'b1, -1, 16'h0, 4'h0, "lzb_off");
`endif
  endtask

  initial begin
    hex_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    test_reset();
    test_basic_scan();
    test_double_buffer();
    test_boundary_load();
    test_enable_mask();
    test_reset_mid();
    test_lzb();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
